// File: rtl/stack_seq_if.sv
// Command channel between the opcode source and stack_seq.
// Valid/ready handshake carrying the opcode and PUSH operand.
interface stack_seq_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/stack_seq.sv
// Word-level sequencer for the bit-lane stack.
// Expands opcodes into one-cycle lane push/pop steps.
module stack_seq #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  stack_seq_if.slave       cmd,
  input  logic [WIDTH-1:0] stk_top,
  output logic [WIDTH-1:0] stk_d,
  output logic             stk_en,
  output logic             stk_dir,
  output logic             stk_clr,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_DUP  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_A,
    S_POP_B,
    S_PUSH_A,
    S_PUSH_B,
    S_PUSH_R,
    S_CLR
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;

  logic             accept;
  logic             has1, has2, room;
  logic [WIDTH-1:0] alu_res;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign has1 = (depth_q != '0);
  assign has2 = (depth_q >= DW'(2));
  assign room = (depth_q <  DW'(DEPTH));

  // Second-from-top (b) combined with former top (a), wrapping.
  assign alu_res = (op_q == OP_SUB) ? (b_q - a_q)
                                    : (b_q + a_q);

  assign depth     = depth_q;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DW'(DEPTH));
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  // Next-state, bookkeeping and lane-control decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    depth_d     = depth_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    stk_en      = 1'b0;
    stk_dir     = 1'b0;
    stk_d       = '0;
    stk_clr     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = cmd.cmd_op;
          a_d  = (cmd.cmd_op == OP_PUSH) ? cmd.cmd_data
                                         : stk_top;
          unique case (cmd.cmd_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (room) state_d = S_PUSH_A;
              else      err_d   = 1'b1;
            end
            OP_POP: begin
              if (has1) state_d = S_POP_A;
              else      err_d   = 1'b1;
            end
            OP_DUP: begin
              if (has1 && room) state_d = S_PUSH_A;
              else              err_d   = 1'b1;
            end
            OP_SWAP, OP_ADD, OP_SUB: begin
              if (has2) state_d = S_POP_A;
              else      err_d   = 1'b1;
            end
            OP_CLR: state_d = S_CLR;
            default: ;
          endcase
        end
      end
      S_POP_A: begin
        stk_en  = 1'b1;
        stk_dir = 1'b1;
        depth_d = depth_q - DW'(1);
        if (op_q == OP_POP) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b1;
          res_data_d  = a_q;
        end else begin
          state_d = S_POP_B;
        end
      end
      S_POP_B: begin
        stk_en  = 1'b1;
        stk_dir = 1'b1;
        b_d     = stk_top;
        depth_d = depth_q - DW'(1);
        state_d = (op_q == OP_SWAP) ? S_PUSH_A
                                    : S_PUSH_R;
      end
      S_PUSH_A: begin
        stk_en  = 1'b1;
        stk_d   = a_q;
        depth_d = depth_q + DW'(1);
        state_d = (op_q == OP_SWAP) ? S_PUSH_B
                                    : S_IDLE;
      end
      S_PUSH_B: begin
        stk_en  = 1'b1;
        stk_d   = b_q;
        depth_d = depth_q + DW'(1);
        state_d = S_IDLE;
      end
      S_PUSH_R: begin
        stk_en      = 1'b1;
        stk_d       = alu_res;
        depth_d     = depth_q + DW'(1);
        res_valid_d = 1'b1;
        res_data_d  = alu_res;
        state_d     = S_IDLE;
      end
      S_CLR: begin
        stk_clr = 1'b1;
        depth_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; rst aborts any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      a_q         <= '0;
      b_q         <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Random and directed bench for stack_seq.
// Lane stack modelled as a word array; reference is a word queue.
module tb_stack_seq;
  localparam int W = 8;
  localparam int D = 8;
  localparam int DW = $clog2(D + 1);

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] DUP  = 3'd3;
  localparam logic [2:0] SWAP = 3'd4;
  localparam logic [2:0] ADD  = 3'd5;
  localparam logic [2:0] SUB  = 3'd6;
  localparam logic [2:0] CLR  = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  stk_top;
  logic [W-1:0]  stk_d;
  logic          stk_en, stk_dir, stk_clr;
  logic [DW-1:0] depth;
  logic          empty, full;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          err;

  stack_seq_if #(.WIDTH(W)) cif ();

  stack_seq #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif.slave),
    .stk_top   (stk_top),
    .stk_d     (stk_d),
    .stk_en    (stk_en),
    .stk_dir   (stk_dir),
    .stk_clr   (stk_clr),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural lane stack: word 0 is the top.
  logic [W-1:0] lanes [D];
  assign stk_top = lanes[0];

  always @(posedge clk) begin
    if (rst || stk_clr) begin
      for (int i = 0; i < D; i++) lanes[i] <= '0;
    end else if (stk_en) begin
      if (!stk_dir) begin
        for (int i = D - 1; i > 0; i--) lanes[i] <= lanes[i-1];
        lanes[0] <= stk_d;
      end else begin
        for (int i = 0; i < D - 1; i++) lanes[i] <= lanes[i+1];
        lanes[D-1] <= '0;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] q[$];
  logic         m_err;
  logic [W-1:0] res_hold;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".depth"}, 32'(depth), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == D));
    chk({tag, ".err"},   32'(err),   32'(m_err));
    chk({tag, ".ready"}, 32'(cif.cmd_ready), 32'd1);
    for (int i = 0; i < D; i++) begin
      logic [W-1:0] e;
      e = (i < q.size()) ? q[i] : '0;
      chk($sformatf("%s.word%0d", tag, i),
          32'(lanes[i]), 32'(e));
    end
  endtask

  // Issue one command from an idle negedge; returns at an idle negedge.
  task automatic do_cmd(input logic [2:0] op,
                        input logic [W-1:0] data,
                        input string tag);
    int n, exp_busy, exp_en, exp_clr;
    int busy, en_n, clr_n, rv_early, guard;
    logic exp_rv;
    logic [W-1:0] exp_rd, ta, tb;
    n = q.size();
    exp_busy = 0;
    exp_clr  = 0;
    exp_rv   = 1'b0;
    exp_rd   = res_hold;
    case (op)
      PUSH: if (n < D) begin
        q.push_front(data); exp_busy = 1;
      end else m_err = 1'b1;
      POP: if (n >= 1) begin
        exp_rd = q.pop_front(); exp_rv = 1'b1; exp_busy = 1;
      end else m_err = 1'b1;
      DUP: if (n >= 1 && n < D) begin
        q.push_front(q[0]); exp_busy = 1;
      end else m_err = 1'b1;
      SWAP: if (n >= 2) begin
        ta = q[0]; q[0] = q[1]; q[1] = ta; exp_busy = 4;
      end else m_err = 1'b1;
      ADD, SUB: if (n >= 2) begin
        ta = q.pop_front();
        tb = q.pop_front();
        exp_rd = (op == ADD) ? tb + ta : tb - ta;
        q.push_front(exp_rd);
        exp_rv = 1'b1; exp_busy = 3;
      end else m_err = 1'b1;
      CLR: begin
        q.delete(); m_err = 1'b0;
        exp_busy = 1; exp_clr = 1;
      end
      default: ;
    endcase
    exp_en = (op == CLR) ? 0 : exp_busy;

    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'($urandom);
    cif.cmd_data  = W'($urandom);
    busy = 0; en_n = 0; clr_n = 0; rv_early = 0; guard = 0;
    while (!cif.cmd_ready && guard < 16) begin
      busy++;
      en_n     += int'(stk_en);
      clr_n    += int'(stk_clr);
      rv_early += int'(res_valid);
      @(negedge clk);
      guard++;
    end
    chk({tag, ".busy"},   32'(busy),     32'(exp_busy));
    chk({tag, ".en_n"},   32'(en_n),     32'(exp_en));
    chk({tag, ".clr_n"},  32'(clr_n),    32'(exp_clr));
    chk({tag, ".rv_mid"}, 32'(rv_early), 32'd0);
    chk({tag, ".rv"},     32'(res_valid), 32'(exp_rv));
    chk({tag, ".rdata"},  32'(res_data), 32'(exp_rd));
    res_hold = exp_rd;
    chk_state(tag);
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = NOP;
    cif.cmd_data  = '0;
    m_err    = 1'b0;
    res_hold = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.rv",    32'(res_valid), 32'd0);
    chk("rst.rdata", 32'(res_data),  32'd0);
    chk("rst.en",    32'(stk_en),    32'd0);
    chk("rst.dir",   32'(stk_dir),   32'd0);
    chk("rst.d",     32'(stk_d),     32'd0);
    chk("rst.clr",   32'(stk_clr),   32'd0);
    chk_state("rst");

    do_cmd(PUSH, 8'h11, "push11");
    do_cmd(PUSH, 8'h22, "push22");
    do_cmd(PUSH, 8'h33, "push33");
    do_cmd(SWAP, 8'h00, "swap");
    do_cmd(NOP,  8'h00, "nop");

    do_cmd(CLR,  8'h00, "clr1");
    do_cmd(PUSH, 8'h20, "p20");
    do_cmd(PUSH, 8'hF0, "pF0");
    do_cmd(ADD,  8'h00, "add_wrap");
    do_cmd(CLR,  8'h00, "clr2");
    do_cmd(PUSH, 8'h00, "p00");
    do_cmd(PUSH, 8'h01, "p01");
    do_cmd(SUB,  8'h00, "sub_wrap");

    do_cmd(CLR,  8'h00, "clr3");
    do_cmd(POP,  8'h00, "pop_empty");
    do_cmd(NOP,  8'h00, "err_sticky");
    for (int i = 0; i < D; i++) do_cmd(PUSH, W'(i + 1), "fill");
    do_cmd(PUSH, 8'hAA, "push_full");
    do_cmd(DUP,  8'h00, "dup_full");
    do_cmd(CLR,  8'h00, "clr_err");

    do_cmd(PUSH, 8'h5A, "dup_seed");
    for (int i = 1; i < D; i++) do_cmd(DUP, 8'h00, "dup");
    do_cmd(POP,  8'h00, "pop_full");

    do_cmd(ADD,  8'h00, "add_pre");
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = ADD;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_err    = 1'b0;
    res_hold = '0;
    chk("abort.rv",    32'(res_valid), 32'd0);
    chk("abort.rdata", 32'(res_data),  32'd0);
    chk("abort.en",    32'(stk_en),    32'd0);
    chk_state("abort");

    for (int k = 0; k < 400; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == CLR && $urandom_range(0, 3) != 0)
        op = PUSH;
      do_cmd(op, W'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
